// File: rtl/rv_imm_pkg.sv
// Shared types and constants for the RISC-V immediate generator/encoder pair.
// Format codes match the imm_gen select so both sides decode one enum.
package rv_imm_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'b000,
    FMT_I   = 3'b001,
    FMT_S   = 3'b010,
    FMT_U   = 3'b011,
    FMT_ISH = 3'b100,
    FMT_B   = 3'b101,
    FMT_J   = 3'b110,
    FMT_RSV = 3'b111
  } imm_fmt_e;

  localparam logic signed [31:0] I_MIN = -32'sd2048;
  localparam logic signed [31:0] I_MAX =  32'sd2047;
  localparam logic signed [31:0] B_MIN = -32'sd4096;
  localparam logic signed [31:0] B_MAX =  32'sd4094;
  localparam logic signed [31:0] J_MIN = -32'sd1048576;
  localparam logic signed [31:0] J_MAX =  32'sd1048574;

  // All-zero word decodes as an illegal instruction on RISC-V.
  localparam logic [31:0] ILLEGAL_INSTR = 32'h0000_0000;

  typedef struct packed {
    imm_fmt_e    fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_req_t;

endpackage

// File: rtl/imm_encoder_range_chk.sv
// Combinational range check: flags immediates that the selected format
// cannot represent exactly.
module imm_range_chk
  import rv_imm_pkg::*;
(
  input  imm_fmt_e    i_fmt,
  input  logic [31:0] i_imm,
  output logic        o_err
);

  logic signed [31:0] w_simm;
  assign w_simm = $signed(i_imm);

  always_comb begin
    o_err = 1'b1;
    case (i_fmt)
      FMT_R:        o_err = 1'b0;
      FMT_I, FMT_S: o_err = (w_simm < I_MIN) || (w_simm > I_MAX);
      // Branch/jump offsets are halfword aligned; bit 0 is not encoded.
      FMT_B:        o_err = (w_simm < B_MIN) || (w_simm > B_MAX) || i_imm[0];
      FMT_J:        o_err = (w_simm < J_MIN) || (w_simm > J_MAX) || i_imm[0];
      FMT_U:        o_err = |i_imm[11:0];
      FMT_ISH:      o_err = |i_imm[31:5];
      default:      o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage RISC-V instruction encoder with valid/ready on both sides.
// S1 holds fields plus range-check result, S2 holds the packed word.
module imm_encoder
  import rv_imm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int STAGES = 2;

  logic [STAGES:1]  r_vld_pipe;
  enc_req_t         r_s1;
  logic             r_s1_err;
  logic [31:0]      r_out_instr;
  logic             r_out_err;
  logic [CNT_W-1:0] r_err_count;

  enc_req_t w_req;
  logic     w_err, w_s1_adv, w_in_fire, w_out_fire;

  assign w_req = '{fmt: imm_fmt_e'(in_fmt), opcode: in_opcode, rd: in_rd,
                   rs1: in_rs1, rs2: in_rs2, funct3: in_funct3,
                   funct7: in_funct7, imm: in_imm};

  imm_range_chk u_chk (.i_fmt(w_req.fmt), .i_imm(in_imm), .o_err(w_err));

  function automatic logic [31:0] pack_instr(input enc_req_t r);
    logic [31:0] v;
    logic [31:0] i;
    i = r.imm;
    v = ILLEGAL_INSTR;
    case (r.fmt)
      FMT_R:   v = {r.funct7, r.rs2, r.rs1, r.funct3, r.rd, r.opcode};
      FMT_I:   v = {i[11:0], r.rs1, r.funct3, r.rd, r.opcode};
      FMT_ISH: v = {r.funct7, i[4:0], r.rs1, r.funct3, r.rd, r.opcode};
      FMT_S:   v = {i[11:5], r.rs2, r.rs1, r.funct3, i[4:0], r.opcode};
      FMT_B:   v = {i[12], i[10:5], r.rs2, r.rs1, r.funct3, i[4:1], i[11], r.opcode};
      FMT_U:   v = {i[31:12], r.rd, r.opcode};
      FMT_J:   v = {i[20], i[10:1], i[11], i[19:12], r.rd, r.opcode};
      default: v = ILLEGAL_INSTR;
    endcase
    return v;
  endfunction

  assign w_out_fire = r_vld_pipe[2] && out_ready;
  assign w_s1_adv   = r_vld_pipe[1] && (!r_vld_pipe[2] || out_ready);
  // Combinational from out_ready so a full pipe can refill with no bubble.
  assign in_ready   = !rst && (!r_vld_pipe[1] || w_s1_adv);
  assign w_in_fire  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_out_instr <= ILLEGAL_INSTR;
      r_out_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_in_fire) begin
        r_vld_pipe[1] <= 1'b1;
        r_s1          <= w_req;
        r_s1_err      <= w_err;
      end else if (w_s1_adv) begin
        r_vld_pipe[1] <= 1'b0;
      end

      if (w_s1_adv) begin
        r_vld_pipe[2] <= 1'b1;
        r_out_instr   <= r_s1_err ? ILLEGAL_INSTR : pack_instr(r_s1);
        r_out_err     <= r_s1_err;
      end else if (out_ready) begin
        r_vld_pipe[2] <= 1'b0;
      end

      if (w_out_fire && r_out_err && !(&r_err_count))
        r_err_count <= r_err_count + 1'b1;
    end
  end

  assign out_valid = r_vld_pipe[2];
  assign out_instr = r_out_instr;
  assign out_err   = r_out_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: hand-encoded words, errors, backpressure,
// saturation of a narrow error counter, and reset mid-stream.
module tb_imm_encoder;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [2:0]    in_fmt;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm;
  logic          out_valid, out_ready;
  logic [31:0]   out_instr;
  logic          out_err;
  logic [CW-1:0] err_count;

  int total = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
    logic        err;
  } tv_t;

  tv_t q[$];

  imm_encoder #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic tv_t mk(input logic [2:0] fmt, input logic [6:0] opc,
                             input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [31:0] imm,
                             input logic [31:0] exp, input logic err);
    tv_t v;
    v.fmt = fmt; v.opc = opc; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp = exp; v.err = err;
    return v;
  endfunction

  task automatic drive(input tv_t v);
    in_valid = 1'b1; in_fmt = v.fmt; in_opcode = v.opc; in_rd = v.rd;
    in_rs1 = v.rs1; in_rs2 = v.rs2; in_funct3 = v.f3; in_funct7 = v.f7;
    in_imm = v.imm;
  endtask

  // Back-to-back issue with out_ready high; word k appears one step after
  // word k+1 is offered, and the pipe is empty one step after the last.
  task automatic run_stream(input string tag);
    int n;
    n = q.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        drive(q[i]);
        #1;
        chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i == 0) begin
        chk({tag, ".lat_vld0"}, {31'b0, out_valid}, 32'd0);
      end else begin
        chk($sformatf("%s.vld[%0d]", tag, i-1), {31'b0, out_valid}, 32'd1);
        chk($sformatf("%s.instr[%0d]", tag, i-1), out_instr, q[i-1].exp);
        chk($sformatf("%s.err[%0d]", tag, i-1), {31'b0, out_err}, {31'b0, q[i-1].err});
      end
    end
    step();
    chk({tag, ".drain"}, {31'b0, out_valid}, 32'd0);
    q.delete();
  endtask

  tv_t w[4];

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;

    // Reset state
    step(); step();
    chk("rst.in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.out_instr", out_instr, 32'h0);
    chk("rst.out_err", {31'b0, out_err}, 32'd0);
    chk("rst.err_count", {29'b0, err_count}, 32'd0);
    rst = 1'b0;
    step();

    // Single words: latency and basic packing
    q.push_back(mk(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 32'h00500093, 1'b0));
    run_stream("addi");
    q.push_back(mk(3'b010, 7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 7'd0, -32'sd4, 32'hFE21AE23, 1'b0));
    run_stream("sw");

    // Valid stream B, U, J back-to-back
    q.push_back(mk(3'b101, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd8, 32'h00208463, 1'b0));
    q.push_back(mk(3'b011, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000, 32'h123452B7, 1'b0));
    q.push_back(mk(3'b110, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 32'h001000EF, 1'b0));
    run_stream("buj");
    chk("buj.err_count", {29'b0, err_count}, 32'd0);

    // Error words
    q.push_back(mk(3'b101, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3, 32'h0, 1'b1));
    q.push_back(mk(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 32'h0, 1'b1));
    q.push_back(mk(3'b111, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 32'h0, 1'b1));
    run_stream("errs");
    chk("errs.err_count", {29'b0, err_count}, 32'd3);

    // Range boundaries, R and I-shamt packing
    q.push_back(mk(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd2048, 32'h80000093, 1'b0));
    q.push_back(mk(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2047, 32'h7FF00093, 1'b0));
    q.push_back(mk(3'b101, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4094, 32'h7E000FE3, 1'b0));
    q.push_back(mk(3'b101, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4096, 32'h0, 1'b1));
    q.push_back(mk(3'b110, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd1048576, 32'h8000006F, 1'b0));
    q.push_back(mk(3'b110, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1048576, 32'h0, 1'b1));
    q.push_back(mk(3'b100, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b001, 7'd0, 32'd31, 32'h01F11093, 1'b0));
    q.push_back(mk(3'b100, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b001, 7'd0, 32'd32, 32'h0, 1'b1));
    q.push_back(mk(3'b011, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345001, 32'h0, 1'b1));
    q.push_back(mk(3'b000, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'hFFFFFFFF, 32'h002081B3, 1'b0));
    q.push_back(mk(3'b000, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 32'd0, 32'h402081B3, 1'b0));
    run_stream("bound");
    chk("bound.err_count", {29'b0, err_count}, 32'd7);

    // Saturation: one more error must not wrap
    q.push_back(mk(3'b111, 7'd0, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 32'h0, 1'b1));
    run_stream("sat");
    chk("sat.err_count", {29'b0, err_count}, 32'd7);

    // Backpressure: 4 words offered, only 2 enter while out_ready low
    w[0] = mk(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, 32'h00100093, 1'b0);
    w[1] = mk(3'b001, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2, 32'h00200113, 1'b0);
    w[2] = mk(3'b001, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3, 32'h00300193, 1'b0);
    w[3] = mk(3'b001, 7'b0010011, 5'd4, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4, 32'h00400213, 1'b0);
    out_ready = 1'b0;
    drive(w[0]); step();
    drive(w[1]); #1;
    chk("bp.in_ready1", {31'b0, in_ready}, 32'd1);
    step();
    drive(w[2]);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp.stall_rdy%0d", k), {31'b0, in_ready}, 32'd0);
      chk($sformatf("bp.stall_vld%0d", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp.stall_instr%0d", k), out_instr, w[0].exp);
      step();
    end
    out_ready = 1'b1; #1;
    chk("bp.release_rdy", {31'b0, in_ready}, 32'd1);
    chk("bp.out0", out_instr, w[0].exp);
    step();
    chk("bp.out1", out_instr, w[1].exp);
    drive(w[3]); #1;
    chk("bp.in_ready3", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp.out2", out_instr, w[2].exp);
    step();
    chk("bp.vld3", {31'b0, out_valid}, 32'd1);
    chk("bp.out3", out_instr, w[3].exp);
    step();
    chk("bp.drain", {31'b0, out_valid}, 32'd0);

    // Reset with two words in flight
    out_ready = 1'b0;
    drive(w[0]); step();
    drive(w[1]); step();
    in_valid = 1'b0;
    chk("mid.full", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    step();
    chk("mid.vld", {31'b0, out_valid}, 32'd0);
    chk("mid.err_count", {29'b0, err_count}, 32'd0);
    chk("mid.in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("mid.quiet", {31'b0, out_valid}, 32'd0);
    q.push_back(mk(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 32'h00500093, 1'b0));
    run_stream("post");

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Pipelined RISC-V instruction encoder: the inverse of `imm_gen`. It accepts decoded fields (format, opcode, registers, funct, signed immediate) and scatters the immediate into the correct bit positions of a 32-bit instruction word. It range-checks the immediate for the selected format. It feeds the instruction-generation path (self-test and boot-stub writer) ahead of instruction memory, using a valid/ready stream on both sides.

## Interface
Parameters:
- `CNT_W`, default 16, width of the saturating error counter.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  input fields valid.
- `in_ready`  out  1  encoder can accept.
- `in_fmt`  in  3  format select: 000 R, 001 I, 010 S, 011 U, 100 I-shamt, 101 B, 110 J, 111 reserved. Same select code as `imm_gen` sig.
- `in_opcode`  in  7  opcode, bits [6:0].
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_funct3`  in  3;  `in_funct7`  in  7.
- `in_imm`  in  32  signed immediate as a full value. For U-format this is the final 32-bit value, low 12 bits expected zero.
- `out_valid`  out  1  encoded word valid.
- `out_ready`  in  1  consumer accepts.
- `out_instr`  out  32  encoded instruction.
- `out_err`  out  1  word flagged unencodable.
- `err_count`  out  CNT_W  saturating count of flagged words delivered.

## Operation
- Two register stages:
  - S1 captures the fields and the registered range-check result.
  - S2 holds the packed `out_instr` and `out_err`.
- Packing, with unused fields ignored:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - I-shamt: funct7|imm[4:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Error conditions, evaluated on the 32-bit signed `in_imm`:
  - I, S: outside [-2048, 2047].
  - B: outside [-4096, 4094], or imm[0]=1.
  - J: outside [-1048576, 1048574], or imm[0]=1.
  - U: imm[11:0] != 0.
  - I-shamt: imm[31:5] != 0.
  - R: never errors.
  - fmt 111: always errors.
- On error: `out_err`=1 and `out_instr`=32'h0000_0000 (illegal instruction). The word is still delivered in order; it is never dropped.
- `err_count` increments by 1 on each output handshake (`out_valid && out_ready`) with `out_err`=1. It holds at all-ones once saturated. Only `rst` clears it.

## Timing
- Reset values:
  - `out_valid`=0, `out_instr`=0, `out_err`=0, `err_count`=0.
  - S1 valid=0.
  - `in_ready`=0 while `rst`=1.
- Input handshake: `in_valid && in_ready` on a rising edge. Output handshake: `out_valid && out_ready`.
- Latency: an accept at edge N gives `out_valid`=1 after edge N+1. Throughput is 1 word/cycle with `out_ready` held high.
- Stall rules:
  - S2 holds its contents while `out_valid && !out_ready`.
  - S1 advances when S1 valid and (`!out_valid || out_ready`).
  - `in_ready = !s1_valid || s1_advance`. This is a combinational path from `out_ready`, and it is intentional.
- Full stall: at most 2 words are in flight. `in_ready`=0 until `out_ready` rises.
- `out_instr` and `out_err` are stable while `out_valid && !out_ready`.
- Simultaneous accept and deliver in one cycle: both occur, with no bubble.
- Reset mid-stream: all in-flight words are discarded and `err_count` is cleared on the first `rst` edge. Nothing is emitted after `rst` deasserts until a new accept.

## Structure
- Package `rv_imm_pkg` holds:
  - `imm_fmt_e` enum, 3-bit, values as above; `imm_gen` also uses it.
  - Range constants: I_MIN/I_MAX, B_MIN/B_MAX, J_MIN/J_MAX.
  - The illegal-word constant 32'h0.
- Sub-module `imm_range_chk`: combinational, takes (fmt, imm) and gives err. It is instantiated before S1.
- Packing and the handshake logic stay in `imm_encoder`.

## Test plan
- I, opcode 0010011, rd=1, rs1=0, funct3=0, imm=5 -> `out_instr`=32'h00500093, `out_err`=0, 2 cycles after accept.
- S, opcode 0100011, rs1=3, rs2=2, funct3=010, imm=-4 -> 32'hFE21AE23.
- Valid-encoding stream:
  - B, opcode 1100011, rs1=1, rs2=2, funct3=0, imm=8 -> 32'h00208463.
  - U, opcode 0110111, rd=5, imm=32'h12345000 -> 32'h123452B7.
  - J, opcode 1101111, rd=1, imm=2048 -> 32'h001000EF.
  - All arrive back-to-back, in order.
- Errors: B with imm=3, then I with imm=2048, then fmt 111 -> three words, each with `out_err`=1 and `out_instr`=0. `err_count`=3.
- Backpressure: hold `out_ready`=0 while offering 4 words -> exactly 2 accepted, `in_ready`=0 and the output stable. Release -> all 4 emerge in order, with no duplicates or drops.
- Reset mid-stream with 2 words in flight -> next cycle `out_valid`=0 and `err_count`=0. Then one new word encodes correctly.
